// File: rtl/lycan.sv
// Shared definitions for the lycan peripheral subsystem.
// Holds the system-wide sizing constants, the TX arbiter state type, the
// USB packet type and a small index helper shared by the arbiters.
package lycan;

    localparam int num_peripherals      = 8;
    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 3;
    localparam int tx_burst_max         = 4;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    typedef logic [usb_packet_width-1:0] usb_packet_t;

    // Next slot index after idx in a ring of n slots (explicit modulo wrap).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin find-first-set.
// Returns the first set bit of req_i at or after ptr_i, searching upward and
// wrapping modulo NUM_REQ. Shared by the TX arbiter and future RX/config
// arbiters.
//   req_i  : request vector
//   ptr_i  : search start index
//   idx_o  : index of the selected request (0 when none)
//   any_o  : at least one request is set
module rr_priority_picker
    import lycan::*;
#(
    parameter int NUM_REQ = num_peripherals,
    parameter int IDX_W   = periph_address_width
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Index reached by stepping off positions upward from base, wrapped.
    function automatic logic [IDX_W-1:0] ring_idx(input int base, input int off);
        return IDX_W'((base + off) % NUM_REQ);
    endfunction

    // Scan from the farthest offset down to the pointer so the closest hit
    // is the last one written and therefore wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[ring_idx(int'(ptr_i), i)]) begin
                idx_o = ring_idx(int'(ptr_i), i);
                any_o = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Round-robin arbiter sharing the upstream USB TX packet path among the
// peripheral slots. One peripheral owns the path for a burst of up to
// MAX_BURST packets; each forwarded packet has its top ADDR_W bits replaced
// by the owner index and leaves through a single registered output stage.
//   clk, rst   : clock and synchronous active-high reset
//   req_valid  : per-peripheral packet valid
//   req_data   : per-peripheral packet (address field ignored)
//   req_ready  : per-peripheral accept (only the owner can see ready)
//   tx_valid   : registered packet valid toward USB TX
//   tx_data    : {owner index, payload}
//   tx_ready   : USB TX accept
//   grant      : one-hot current owner, 0 while idle
//   busy       : a peripheral currently owns the path
module periph_tx_arbiter
    import lycan::*;
#(
    parameter int NUM_REQ   = num_peripherals,
    parameter int DATA_W    = usb_packet_width,
    parameter int ADDR_W    = periph_address_width,
    parameter int MAX_BURST = tx_burst_max
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [DATA_W-1:0] req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic [ADDR_W-1:0] sel_idx_s;
    logic              sel_any_s;
    logic              out_free_s;
    logic              own_valid_s;
    logic              xfer_s;
    logic [DATA_W-1:0] tagged_s;
    logic              unused_addr_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ADDR_W)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .idx_o (sel_idx_s),
        .any_o (sel_any_s)
    );

    // The output stage can take a packet when empty or draining this cycle.
    assign out_free_s  = !tx_valid_q || tx_ready;
    assign own_valid_s = req_valid[owner_q];
    assign xfer_s      = (state_q == ARB_GRANT) && own_valid_s && out_free_s;
    assign tagged_s    = {owner_q, req_data[owner_q][DATA_W-ADDR_W-1:0]};

    // The incoming address field is overwritten, so its bits are only folded
    // into a dummy to mark them as intentionally ignored.
    always_comb begin
        unused_addr_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            unused_addr_s = unused_addr_s ^ (^req_data[i][DATA_W-1 -: ADDR_W]);
        end
    end

    // Arbitration FSM: ownership, burst counting and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_any_s) begin
                    owner_d     = sel_idx_s;
                    burst_cnt_d = '0;
                    state_d     = ARB_GRANT;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (xfer_s) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_d == CNT_W'(MAX_BURST)) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = ADDR_W'(wrap_inc(int'(owner_q), NUM_REQ));
                    end else begin
                        state_d = ARB_GRANT;
                    end
                end else if (out_free_s) begin
                    // Ready was offered but the owner had nothing to send.
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ADDR_W'(wrap_inc(int'(owner_q), NUM_REQ));
                end else begin
                    // Output stalled: ownership is frozen until it drains.
                    state_d = ARB_GRANT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output register: load on transfer, clear once consumed, hold on stall.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (xfer_s) begin
            tx_valid_d = 1'b1;
            tx_data_d  = tagged_s;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end
    end

    // Per-peripheral ready and one-hot grant decode for the current owner.
    always_comb begin
        req_ready = '0;
        grant     = '0;
        if (state_q == ARB_GRANT) begin
            req_ready[owner_q] = out_free_s;
            grant[owner_q]     = 1'b1;
        end else begin
            req_ready = '0;
            grant     = '0;
        end
    end

    assign busy     = (state_q == ARB_GRANT);
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// Self-checking bench for periph_tx_arbiter.
// Each requester is fed from a packet list; when a scenario is loaded, a
// transaction-level round-robin model computes the complete expected TX
// sequence and pushes it into a scoreboard queue. An independent monitor
// pops and compares on every TX handshake. Directed scenarios add timing
// checks on grant, ready and output hold behaviour.
module tb_periph_tx_arbiter;
    import lycan::*;

    localparam int N  = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [31:0]   req_data [N];
    logic [N-1:0]  req_ready;
    logic          tx_valid;
    logic [31:0]   tx_data;
    logic          tx_ready = 1'b0;
    logic [N-1:0]  grant;
    logic          busy;

    periph_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (32),
        .ADDR_W    (3),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Source packet lists per requester.
    logic [31:0] src_mem [N][64];
    int          src_head [N];
    int          src_tail [N];
    logic [N-1:0] acc = '0;

    usb_packet_t exp_q [$];
    int          model_ptr = 0;

    // Per-cycle logs of the current scenario.
    logic [7:0]  grant_log [512];
    logic [7:0]  rdy_log   [512];
    logic        busy_log  [512];
    logic        txv_log   [512];
    logic [31:0] data_log  [512];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tag(input int src, input logic [31:0] pkt);
        logic [31:0] t;
        t = pkt;
        t[31:29] = 3'(src);
        return t;
    endfunction

    // Transaction-level round robin: from the pointer, pick the first
    // requester with packets left, take up to MB of them, move past it.
    task automatic build_expect();
        int pos [N];
        int p;
        int sel;
        int n;
        bit found;
        p = model_ptr;
        for (int i = 0; i < N; i++) pos[i] = src_head[i];
        forever begin
            found = 1'b0;
            sel = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && pos[(p + k) % N] < src_tail[(p + k) % N]) begin
                    sel = (p + k) % N;
                    found = 1'b1;
                end
            end
            if (!found) break;
            n = src_tail[sel] - pos[sel];
            if (n > MB) n = MB;
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(tag(sel, src_mem[sel][pos[sel]]));
                pos[sel]++;
            end
            p = (sel + 1) % N;
        end
        model_ptr = p;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
    endtask

    task automatic load(input int idx, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            src_mem[idx][src_tail[idx]] = $urandom();
            src_tail[idx]++;
        end
    endtask

    // One clock of stimulus: retire last cycle's handshakes, then drive.
    task automatic cycle(input logic r, input logic rdy);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) src_head[i]++;
        end
        rst = r;
        tx_ready = rdy;
        for (int i = 0; i < N; i++) begin
            if (!r && src_head[i] < src_tail[i]) begin
                req_valid[i] = 1'b1;
                req_data[i] = src_mem[i][src_head[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i] = $urandom();
            end
        end
        #1;
        acc = req_valid & req_ready;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] != src_tail[i]) return 1'b0;
        end
        return (acc == '0);
    endfunction

    // mode 0: tx_ready high; 1: random; 2: low in cycles 3..7.
    task automatic run(input int mode, input int budget);
        int c;
        logic rdy;
        c = 0;
        forever begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 9) < 7);
                default: rdy = !(c >= 3 && c <= 7);
            endcase
            cycle(1'b0, rdy);
            if (c < 512) begin
                grant_log[c] = grant;
                rdy_log[c]   = req_ready;
                busy_log[c]  = busy;
                txv_log[c]   = tx_valid;
                data_log[c]  = tx_data;
            end
            c++;
            if (all_empty() && exp_q.size() == 0) break;
            if (c >= budget) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                clear_src();
                acc = '0;
                break;
            end
        end
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0);
        model_ptr = 0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: compares every packet the DUT hands to USB TX.
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        #2;
        if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_extra: got %h expected no packet at %0t", tx_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("tx_data", tx_data, mon_exp);
            end
        end
    end

    initial begin
        bit hit;
        for (int i = 0; i < N; i++) req_data[i] = '0;
        clear_src();

        // Reset state
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single requester: tagging and latency
        src_mem[3][0] = 32'h0000_0ABC;
        src_mem[3][1] = 32'h1FFF_FFFF;
        src_tail[3] = 2;
        build_expect();
        run(0, 100);
        chk("t1_grant_c0", 32'(grant_log[0]), 32'h00);
        chk("t1_grant_c1", 32'(grant_log[1]), 32'h08);
        chk("t1_txv_c1", 32'(txv_log[1]), 32'd0);
        chk("t1_txv_c2", 32'(txv_log[2]), 32'd1);
        chk("t1_data_c2", data_log[2], 32'h6000_0ABC);
        chk("t1_data_c3", data_log[3], 32'h7FFF_FFFF);

        // All requesters busy: full rotation, 4 each, one idle between owners
        do_reset();
        clear_src();
        for (int i = 0; i < N; i++) load(i, 4);
        build_expect();
        run(0, 200);
        for (int c = 0; c <= 40; c++) begin
            if (c % 5 == 0 || c == 40) chk("t2_grant_idle", 32'(grant_log[c]), 32'h00);
            else chk("t2_grant_owner", 32'(grant_log[c]), 32'(8'h01 << (c / 5)));
        end

        // Stall mid-burst on requester 2
        clear_src();
        load(2, 8);
        build_expect();
        run(2, 200);
        for (int c = 3; c <= 7; c++) begin
            chk("t3_ready_stall", 32'(rdy_log[c]), 32'h00);
            chk("t3_txv_stall", 32'(txv_log[c]), 32'd1);
        end
        for (int c = 3; c <= 8; c++) begin
            chk("t3_data_hold", data_log[c], tag(2, src_mem[2][1]));
        end

        // Early release: 5 runs dry while 2 and 6 wait
        clear_src();
        load(5, 2);
        load(6, 1);
        load(2, 1);
        build_expect();
        run(1, 200);
        clear_src();
        load(5, 2);
        load(6, 1);
        load(2, 1);
        build_expect();
        run(0, 200);
        chk("t4_grant_5", 32'(grant_log[1]), 32'h20);
        chk("t4_grant_6", 32'(grant_log[5]), 32'h40);
        chk("t4_grant_2", 32'(grant_log[8]), 32'h04);

        // Pointer wrap after owner 7
        clear_src();
        load(7, 5);
        load(0, 1);
        build_expect();
        run(0, 200);
        chk("t5_grant_7", 32'(grant_log[1]), 32'h80);
        chk("t5_grant_0", 32'(grant_log[6]), 32'h01);

        // Randomized traffic with random back-pressure
        for (int r = 0; r < 6; r++) begin
            clear_src();
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 6));
            build_expect();
            run(1, 800);
        end

        // Reset in the middle of owner 6's burst
        do_reset();
        clear_src();
        load(4, 8);
        load(6, 4);
        build_expect();
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            cycle(1'b0, 1'b1);
            if (grant === 8'h40 && tx_valid === 1'b1) hit = 1'b1;
        end
        chk("t6_reach_mid_burst", 32'(hit), 32'd1);
        cycle(1'b1, 1'b0);
        exp_q.delete();
        model_ptr = 0;
        build_expect();
        run(0, 200);
        chk("t6_txv_after_rst", 32'(txv_log[0]), 32'd0);
        chk("t6_grant_after_rst", 32'(grant_log[0]), 32'h00);
        chk("t6_ready_after_rst", 32'(rdy_log[0]), 32'h00);
        chk("t6_busy_after_rst", 32'(busy_log[0]), 32'd0);
        chk("t6_data_after_rst", data_log[0], 32'd0);
        chk("t6_first_grant", 32'(grant_log[1]), 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
